// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the instruction width, the PC-select encodings used by the control
// unit, the fetch FSM state codes and a small word-alignment helper.
package instruction_fetch_unit_pkg;

  localparam int INSTR_W = 32;

  // PC-select encodings driven by the control unit
  localparam logic [1:0] PC_SEL_NEXT = 2'b00;  // pc + 4
  localparam logic [1:0] PC_SEL_REL  = 2'b01;  // pc + (K << 2)
  localparam logic [1:0] PC_SEL_REG  = 2'b10;  // register target (BR)
  localparam logic [1:0] PC_SEL_HALT = 2'b11;  // stop fetching

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // Clear the byte-offset bits so a register target lands on a word boundary
  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_next_logic.sv
// Next-PC computation for the instruction fetch unit (purely combinational).
// Ports:
//   i_pc            current instruction address
//   i_pc_sel        control-unit PC select (NEXT / REL / REG / HALT)
//   i_k             sign-extended branch offset in words
//   i_reg_a         register branch target
//   o_next_pc       address of the next instruction to fetch
//   o_misalign_hit  register target had non-zero byte-offset bits
module pc_next_logic
  import instruction_fetch_unit_pkg::*;
(
  input  logic [63:0] i_pc,
  input  logic [1:0]  i_pc_sel,
  input  logic [63:0] i_k,
  input  logic [63:0] i_reg_a,
  output logic [63:0] o_next_pc,
  output logic        o_misalign_hit
);

  logic signed [63:0] w_k_signed;
  logic signed [63:0] w_k_bytes;

  assign w_k_signed = $signed(i_k);
  // Word offset to byte offset; wraps mod 2^64 like the rest of the PC math
  assign w_k_bytes  = w_k_signed <<< 2;

  always_comb begin
    o_next_pc      = i_pc;
    o_misalign_hit = 1'b0;
    case (i_pc_sel)
      PC_SEL_NEXT: o_next_pc = i_pc + 64'd4;
      PC_SEL_REL:  o_next_pc = i_pc + $unsigned(w_k_bytes);
      PC_SEL_REG: begin
        o_next_pc      = align_word(i_reg_a);
        o_misalign_hit = |i_reg_a[1:0];
      end
      default:     o_next_pc = i_pc;  // halt keeps the PC
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches 32-bit instructions over a req/ack
// handshake, holds each one stable for the multi-state control unit and
// advances the PC according to the control unit's PC select on completion.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   imem_req/addr       fetch request and address (addr = pc low bits)
//   imem_ack/rdata      memory response, only honoured in FETCH
//   instruction/valid   instruction register towards the control unit
//   instr_done          control unit finished the current instruction
//   pc_sel, k_in        next-PC select and word branch offset
//   reg_a_in            register branch target
//   pc, pc_plus4        current address and link value
//   halted, misalign    halt reached / sticky unaligned register target
//   instr_count         retired instruction counter (wraps)
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          ADDR_BITS = 64,
  parameter int          CNT_BITS  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic [INSTR_W-1:0]   instruction,
  output logic                 instr_valid,
  input  logic                 instr_done,
  input  logic [1:0]           pc_sel,
  input  logic [63:0]          k_in,
  input  logic [63:0]          reg_a_in,
  output logic [63:0]          pc,
  output logic [63:0]          pc_plus4,
  output logic                 halted,
  output logic                 misalign,
  output logic [CNT_BITS-1:0]  instr_count
);

  fetch_state_t        r_state;
  logic [63:0]         r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_valid;
  logic                r_req;
  logic                r_halted;
  logic                r_misalign;
  logic [CNT_BITS-1:0] r_count;

  fetch_state_t        w_state_nxt;
  logic [63:0]         w_pc_nxt;
  logic [INSTR_W-1:0]  w_instr_nxt;
  logic                w_valid_nxt;
  logic                w_req_nxt;
  logic                w_halted_nxt;
  logic                w_misalign_nxt;
  logic [CNT_BITS-1:0] w_count_nxt;

  logic [63:0]         w_next_pc;
  logic                w_misalign_hit;

  pc_next_logic u_pc_next (
    .i_pc           (r_pc),
    .i_pc_sel       (pc_sel),
    .i_k            (k_in),
    .i_reg_a        (reg_a_in),
    .o_next_pc      (w_next_pc),
    .o_misalign_hit (w_misalign_hit)
  );

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_req      <= 1'b0;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_valid    <= w_valid_nxt;
      r_req      <= w_req_nxt;
      r_halted   <= w_halted_nxt;
      r_misalign <= w_misalign_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_valid_nxt    = r_valid;
    w_req_nxt      = r_req;
    w_halted_nxt   = r_halted;
    w_misalign_nxt = r_misalign;
    w_count_nxt    = r_count;

    case (r_state)
      ST_IDLE: begin
        // First edge out of reset starts fetching; a stray ack here is ignored
        w_state_nxt = ST_FETCH;
        w_req_nxt   = 1'b1;
      end

      ST_FETCH: begin
        w_req_nxt = 1'b1;
        if (imem_ack) begin
          w_instr_nxt = imem_rdata;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Instruction and PC stay frozen until the control unit completes
        if (instr_done) begin
          w_count_nxt = r_count + CNT_BITS'(1);
          w_valid_nxt = 1'b0;
          if (pc_sel == PC_SEL_HALT) begin
            w_req_nxt    = 1'b0;
            w_halted_nxt = 1'b1;
            w_state_nxt  = ST_HALT;
          end else begin
            w_pc_nxt       = w_next_pc;
            w_misalign_nxt = r_misalign | w_misalign_hit;
            // Request goes out on the same edge to keep 2 cycles/instruction
            w_req_nxt      = 1'b1;
            w_state_nxt    = ST_FETCH;
          end
        end
      end

      ST_HALT: begin
        w_req_nxt    = 1'b0;
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc[ADDR_BITS-1:0];
  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 64'd4;
  assign halted      = r_halted;
  assign misalign    = r_misalign;
  assign instr_count = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_done;
  logic [1:0]  pc_sel;
  logic [63:0] k_in;
  logic [63:0] reg_a_in;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        halted;
  logic        misalign;
  logic [31:0] instr_count;

  instruction_fetch_unit #(
    .RESET_PC  (RST_PC),
    .ADDR_BITS (64),
    .CNT_BITS  (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_done  (instr_done),
    .pc_sel      (pc_sel),
    .k_in        (k_in),
    .reg_a_in    (reg_a_in),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .halted      (halted),
    .misalign    (misalign),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state (architectural view)
  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;
  logic        m_halt;
  logic [63:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];

  // Memory responder vs. manual ack override
  logic        mem_en;
  int          lat;
  int          wait_cnt;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic        man_ack;
  logic [31:0] man_data;

  assign imem_ack   = mem_en ? resp_ack  : man_ack;
  assign imem_rdata = mem_en ? resp_data : man_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_cnt  = 0;
    m_mis  = 1'b0;
    m_halt = 1'b0;
    exp_addr_q.delete();
    exp_instr_q.delete();
  endtask

  // Memory: acknowledges after 'lat' wait cycles with a random word
  initial begin
    resp_ack  = 1'b0;
    resp_data = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!mem_en || reset) begin
        resp_ack = 1'b0;
        wait_cnt = 0;
      end else if (imem_req && !resp_ack) begin
        if (wait_cnt >= lat) begin
          resp_ack  = 1'b1;
          resp_data = $urandom;
          exp_instr_q.push_back(resp_data);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        resp_ack = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  logic        p_req, p_valid;
  logic [31:0] p_instr;
  logic [63:0] l_addr;
  initial begin
    p_req = 0; p_valid = 0; p_instr = 0; l_addr = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        p_req   = 1'b0;
        p_valid = 1'b0;
      end else begin
        if (imem_req && !p_req) begin
          if (exp_addr_q.size() == 0) chk("unexpected_fetch", 1, 0);
          else chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
          l_addr = imem_addr;
        end else if (imem_req) begin
          chk("addr_stable", imem_addr, l_addr);
          chk("instr_hold_in_fetch", instruction, p_instr);
        end
        if (instr_valid && !p_valid) begin
          if (exp_instr_q.size() == 0) chk("unexpected_instr", 1, 0);
          else chk("instr_word", instruction, exp_instr_q.pop_front());
          chk("pc", pc, m_pc);
          chk("pc_plus4", pc_plus4, m_pc + 64'd4);
          chk("instr_count", instr_count, m_cnt);
          chk("misalign", misalign, m_mis);
        end else if (instr_valid) begin
          chk("instr_stable", instruction, p_instr);
        end
        if (m_halt) chk("halt_no_req", imem_req, 0);
        p_req   = imem_req;
        p_valid = instr_valid;
        p_instr = instruction;
      end
    end
  end

  // Play the control unit for one instruction
  task automatic exec_instr(input logic [1:0] sel, input logic [63:0] k,
                            input logic [63:0] ra, input int hold);
    int t;
    logic signed [63:0] ks;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!instr_valid && t < 500);
    if (!instr_valid) begin
      chk("exec_wait_timeout", 0, 1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("no_fetch_while_exec", imem_req, 0);
      chk("valid_held", instr_valid, 1);
    end
    @(posedge clock);
    #1;
    instr_done = 1'b1;
    pc_sel     = sel;
    k_in       = k;
    reg_a_in   = ra;
    ks         = $signed(k);
    m_cnt      = m_cnt + 1;
    case (sel)
      2'b00: m_pc = m_pc + 64'd4;
      2'b01: m_pc = m_pc + $unsigned(ks * 64'sd4);
      2'b10: begin
        m_pc = ra - (ra % 64'd4);
        if ((ra % 64'd4) != 0) m_mis = 1'b1;
      end
      default: m_halt = 1'b1;
    endcase
    if (sel != 2'b11) exp_addr_q.push_back(m_pc);
    @(posedge clock);
    #1;
    instr_done = 1'b0;
    pc_sel     = 2'($urandom);
    k_in       = {$urandom, $urandom};
    reg_a_in   = {$urandom, $urandom};
  endtask

  initial begin
    int t;
    reset = 1'b1;
    instr_done = 1'b0;
    pc_sel = 2'b00;
    k_in = '0;
    reg_a_in = '0;
    mem_en = 1'b1;
    lat = 0;
    man_ack = 1'b0;
    man_data = '0;
    model_reset();

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instruction, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_pc_plus4", pc_plus4, RST_PC + 64'd4);

    exp_addr_q.push_back(RST_PC);
    @(posedge clock);
    #1 reset = 1'b0;

    // Zero-wait sequential fetches 0,4,8,12
    exec_instr(2'b00, 0, 0, 0);
    exec_instr(2'b00, 0, 0, 0);
    exec_instr(2'b00, 0, 0, 0);
    // Slow memory for the next fetch
    lat = 5;
    exec_instr(2'b00, 0, 0, 0);
    lat = 0;
    // Jump to 0x100, then relative -2 words -> 0xF8
    exec_instr(2'b10, 0, 64'h100, 0);
    exec_instr(2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    // Unaligned register target, then an aligned one (misalign sticky)
    exec_instr(2'b10, 0, 64'h2003, 0);
    exec_instr(2'b10, 0, 64'h3000, 0);
    // Wrap at top of address space
    exec_instr(2'b10, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    exec_instr(2'b00, 0, 0, 1);

    // Randomised run
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  s;
      logic [63:0] k;
      s = 2'($urandom_range(0, 2));
      k = 64'($signed($urandom_range(0, 40)) - 20);
      lat = $urandom_range(0, 3);
      exec_instr(s, k, {$urandom, $urandom}, $urandom_range(0, 2));
    end
    lat = 0;

    // Long multi-state instruction then halt
    exec_instr(2'b00, 0, 0, 3);
    exec_instr(2'b11, 0, 0, 3);
    mem_en = 1'b0;
    man_ack = 1'b1;
    man_data = 32'hA5A5_A5A5;
    instr_done = 1'b1;
    pc_sel = 2'b00;
    repeat (10) begin
      @(negedge clock);
      chk("halted", halted, 1);
      chk("halt_valid", instr_valid, 0);
    end
    man_ack = 1'b0;
    instr_done = 1'b0;

    // Reset during a fetch, stray ack while in IDLE
    reset = 1'b1;
    model_reset();
    exp_addr_q.push_back(RST_PC);
    @(posedge clock);
    #1 reset = 1'b0;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!imem_req && t < 20);
    chk("pre_reset_req", imem_req, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_req_drop", imem_req, 0);
    chk("async_halted", halted, 0);
    chk("async_count", instr_count, 0);
    model_reset();
    exp_addr_q.push_back(RST_PC);
    @(posedge clock);
    #1;
    reset = 1'b0;
    man_ack = 1'b1;
    man_data = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    man_ack = 1'b0;
    mem_en = 1'b1;
    exec_instr(2'b00, 0, 0, 0);
    exec_instr(2'b11, 0, 0, 0);
    repeat (5) @(negedge clock);
    chk("final_halted", halted, 1);
    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("instr_q_empty", exp_instr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
